pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It generates the PC write enable (wpc) for the fetch stage, the IF/ID write-enable and flush, the ID/EX bubble and a global enable for downstream stage registers. It detects load-use hazards and taken-branch flushes, and implements a free-run / single-step / halt run-control FSM for board debugging. It also keeps saturating cycle and stall counters for the debug display.

Parameters:
CNT_W, 16, width of cycle_cnt and stall_cnt
SYNC_STAGES, 2, flops in the step-input synchroniser (minimum 2)
REG_W, 5, register-specifier width

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
run_mode  input  1  1 = free run, 0 = single-step
step  input  1  debounced step button (async level)
halt_req  input  1  level halt request
id_rs  input  REG_W  rs field of instruction in ID
id_rt  input  REG_W  rt field of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  instruction in EX is LW
ex_rd  input  REG_W  destination register of instruction in EX
id_branch_taken  input  1  branch/jump resolved taken in ID
wpc  output  1  PC write enable to fetch stage
if_id_wen  output  1  IF/ID register write enable
if_id_flush  output  1  clear IF/ID to NOP
id_ex_bubble  output  1  load NOP into ID/EX
pipe_en  output  1  enable for ID/EX, EX/MEM, MEM/WB registers
cpu_state  output  2  FSM state code
cycle_cnt  output  CNT_W  advance cycles since reset
stall_cnt  output  CNT_W  load-use stall cycles since reset

Behaviour:
- Reset (async, rst=1): state IDLE; all control outputs 0; both counters 0; synchroniser and edge flop cleared. Reset asserted mid-operation aborts everything immediately. No stall or flush state survives reset.
- State codes: IDLE=0, RUN=1, STEP=2, HALTED=3.
- IDLE: held for exactly one cycle after rst deasserts, then RUN.
- RUN:
  - halt_req=1 -> HALTED.
  - Otherwise, run_mode=0 -> STEP.
  - halt has priority over the mode change.
- STEP:
  - halt_req=1 -> HALTED.
  - Otherwise, run_mode=1 -> RUN.
- HALTED:
  - halt_req=0 and run_mode=1 -> RUN.
  - halt_req=0 and run_mode=0 -> STEP.
- step is passed through a SYNC_STAGES-flop synchroniser, then a rising-edge detect. One step press gives exactly one step_pulse cycle, SYNC_STAGES+1 cycles after the edge. Holding step produces no further pulses.
- adv (internal, combinational):
  - 1 when state=RUN.
  - step_pulse when state=STEP.
  - 0 in IDLE and HALTED.
- hazard (combinational), 1 when all of the following hold:
  - ex_mem_read=1 and ex_rd!=0;
  - (id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd).
- Outputs are combinational from state, adv and the ID/EX inputs (zero latency), in four cases:
  - adv=0: wpc, if_id_wen, if_id_flush, id_ex_bubble and pipe_en are all 0. The pipeline is frozen and no bubble is inserted.
  - adv=1 and hazard=1: wpc=0, if_id_wen=0, if_id_flush=0, id_ex_bubble=1, pipe_en=1. Hazard has priority over id_branch_taken, because branch operands are not yet ready.
  - adv=1, hazard=0, id_branch_taken=1: wpc=1, if_id_wen=1, if_id_flush=1, id_ex_bubble=0, pipe_en=1. This gives exactly one delay-slot kill.
  - adv=1, no hazard, no branch: wpc=1, if_id_wen=1, pipe_en=1, others 0.
- Counters:
  - cycle_cnt increments on every adv=1 cycle.
  - stall_cnt increments on every adv=1 and hazard=1 cycle.
  - Both saturate at all-ones and do not wrap.
- A halt_req arriving in the same cycle as a step_pulse: the FSM goes to HALTED, but that cycle still advances because it was in STEP with a pulse.
- A hazard persisting across cycles stalls for each cycle it persists. Normally one cycle, since the LW moves to MEM.

Decomposition:
- Shared constants in macro.vh: the CPU_STATE_IDLE/RUN/STEP/HALTED codes, consumed by the debug display.
- One sub-module, step_sync: the SYNC_STAGES synchroniser plus rising-edge detector, output step_pulse.
- Hazard compare and the FSM stay in the top module.

Test Plan:
- Reset release, run_mode=1, no hazards: cpu_state 0 for 1 cycle, then 1. wpc=1 every following cycle. After 10 cycles cycle_cnt=10, stall_cnt=0.
- RUN, ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle: that cycle wpc=0, if_id_wen=0, id_ex_bubble=1. stall_cnt 0->1. Next cycle wpc=1.
- Same as above, but ex_rd=0, or id_uses_rs=0 with id_rt!=8: no stall, wpc=1.
- Hazard and id_branch_taken together, then branch alone next cycle: cycle 1 bubble with if_id_flush=0. Cycle 2 if_id_flush=1, wpc=1.
- run_mode=0, single step press held 20 cycles: exactly one cycle with wpc=1, SYNC_STAGES+1=3 cycles after the edge. cycle_cnt +1.
- halt_req=1 in RUN: next cycle cpu_state=3, all enables 0, counters frozen. halt_req=0 -> RUN.
- rst pulse mid-stall: outputs 0 and counters 0 immediately.
- CNT_W=4, run 20 cycles: cycle_cnt holds at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall / run-control sequencer.
//   - CPU_STATE_* codes: state encoding also consumed by the debug display.
//   - cpu_state_e: FSM state type built on those codes.
//   - ctrl_t / ctrl_decode: pipeline control bundle and its decode from adv/hazard/branch.
package pipe_stall_ctrl_pkg;

   localparam logic [1:0] CPU_STATE_IDLE   = 2'd0;
   localparam logic [1:0] CPU_STATE_RUN    = 2'd1;
   localparam logic [1:0] CPU_STATE_STEP   = 2'd2;
   localparam logic [1:0] CPU_STATE_HALTED = 2'd3;

   typedef enum logic [1:0] {
      StIdle   = CPU_STATE_IDLE,
      StRun    = CPU_STATE_RUN,
      StStep   = CPU_STATE_STEP,
      StHalted = CPU_STATE_HALTED
   } cpu_state_e;

   typedef struct packed {
      logic wpc;
      logic if_id_wen;
      logic if_id_flush;
      logic id_ex_bubble;
      logic pipe_en;
   } ctrl_t;

   // Load-use hazard wins over a taken branch: the branch operands are not ready yet,
   // so the branch is re-evaluated next cycle once the bubble has gone through.
   function automatic ctrl_t ctrl_decode(input logic adv, input logic hazard, input logic branch);
      ctrl_t c;
      c = '0;
      if (adv) begin
         c.pipe_en = 1'b1;
         if (hazard) begin
            c.id_ex_bubble = 1'b1;
         end else begin
            c.wpc         = 1'b1;
            c.if_id_wen   = 1'b1;
            c.if_id_flush = branch;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_step_sync.sv
// Step-button synchroniser and rising-edge detector.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   step_i       asynchronous step level (already debounced)
//   step_pulse_o one-cycle pulse, SYNC_STAGES+1 cycles after a rising edge of step_i
module pipe_stall_ctrl_step_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic step_i,
   output logic step_pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d;
   logic                   pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], step_i};
      edge_d  = sync_q[SYNC_STAGES-1];
      // Registered so downstream logic sees a clean single-cycle pulse.
      pulse_d = sync_q[SYNC_STAGES-1] & ~edge_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         edge_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         edge_q  <= edge_d;
         pulse_q <= pulse_d;
      end
   end

   assign step_pulse_o = pulse_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central sequencer for the 5-stage pipeline: load-use stall, taken-branch flush,
// free-run / single-step / halt run control, and saturating debug counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   run_mode, step, halt_req run control (1 = free run; step button; halt level)
//   id_rs, id_rt, id_uses_*  source operands of the instruction in ID
//   ex_mem_read, ex_rd       load-in-EX indication and its destination
//   id_branch_taken          branch/jump resolved taken in ID
//   wpc, if_id_wen           PC and IF/ID write enables
//   if_id_flush              clear IF/ID to NOP
//   id_ex_bubble             load NOP into ID/EX
//   pipe_en                  enable for ID/EX, EX/MEM, MEM/WB
//   cpu_state                FSM state code
//   cycle_cnt, stall_cnt     saturating advance / load-use stall counters
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned REG_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_mode,
   input  logic             step,
   input  logic             halt_req,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_branch_taken,
   output logic             wpc,
   output logic             if_id_wen,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_en,
   output logic [1:0]       cpu_state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   cpu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             step_pulse;
   logic             adv;
   logic             hazard;
   ctrl_t            ctrl;

   pipe_stall_ctrl_step_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_step_sync (
      .clk          (clk),
      .rst          (rst),
      .step_i       (step),
      .step_pulse_o (step_pulse)
   );

   // Register 0 is hard-wired, so a load into it never creates a dependency.
   always_comb begin
      hazard = 1'b0;
      if (ex_mem_read && (ex_rd != '0)) begin
         hazard = (id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd));
      end
   end

   always_comb begin
      adv = 1'b0;
      unique case (state_q)
         StRun:   adv = 1'b1;
         StStep:  adv = step_pulse;
         default: adv = 1'b0;
      endcase
   end

   // Halt takes priority over a mode change; a step pulse coinciding with a halt
   // still advances this cycle because adv depends only on the current state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: state_d = StRun;
         StRun: begin
            if (halt_req)       state_d = StHalted;
            else if (!run_mode) state_d = StStep;
         end
         StStep: begin
            if (halt_req)      state_d = StHalted;
            else if (run_mode) state_d = StRun;
         end
         StHalted: begin
            if (!halt_req) state_d = run_mode ? StRun : StStep;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cycle_d = cycle_q;
      stall_d = stall_q;
      if (adv && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;
      if (adv && hazard && (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cycle_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
      end
   end

   assign ctrl         = ctrl_decode(adv, hazard, id_branch_taken);
   assign wpc          = ctrl.wpc;
   assign if_id_wen    = ctrl.if_id_wen;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign pipe_en      = ctrl.pipe_en;
   assign cpu_state    = state_q;
   assign cycle_cnt    = cycle_q;
   assign stall_cnt    = stall_q;

endmodule
